pcie_msi_irq_arb: RTL
=====================

Name: pcie_msi_irq_arb

Overview:
Multi-source MSI interrupt request arbiter. It sits between user logic (fpga_core-level IRQ sources) and the PCIe hard block's cfg_interrupt_msi_* interface. It latches per-source events into pending bits, honours the host's MSI enable, multiple-message enable and per-vector mask, then issues one request at a time round-robin. It completes the sent/fail handshake, with timeout, back-off and retry.

Parameters:
IRQ_COUNT, 32, number of interrupt sources (1..32)
IRQ_EDGE, 1, 1 = rising edge of irq[i] sets pending; 0 = level, pending set every cycle irq[i] high
RETRY_DELAY, 16, back-off cycles after fail/timeout before next issue (>=1)
WAIT_TIMEOUT, 1024, cycles in WAIT without sent/fail before treating as fail
STAT_WIDTH, 16, width of saturating statistics counters

Ports:
clk  in  1  PCIe user clock
rst_n  in  1  asynchronous active-low reset
irq  in  IRQ_COUNT  interrupt sources, synchronous to clk
cfg_interrupt_msi_enable  in  1  function 0 MSI enable bit
cfg_interrupt_msi_mmenable  in  3  log2 of enabled vector count
cfg_interrupt_msi_mask_update  in  1  one-cycle pulse: mask register changed
cfg_interrupt_msi_data  in  32  mask value, valid with mask_update
cfg_interrupt_msi_select  out  4  mask read select, constant 0
cfg_interrupt_msi_int  out  32  one-hot request pulse
cfg_interrupt_msi_sent  in  1  request delivered
cfg_interrupt_msi_fail  in  1  request failed
cfg_interrupt_msi_pending_status  out  32  pending vectors
cfg_interrupt_msi_pending_status_data_enable  out  1  pulse: pending_status updated
stat_sent_count  out  STAT_WIDTH  saturating count of sent
stat_fail_count  out  STAT_WIDTH  saturating count of fail+timeout
busy  out  1  FSM not in IDLE

Behaviour:
- Reset (rst_n low, async): pending=0, mask=0, rr pointer=0, FSM=IDLE, all outputs 0, counters 0, irq edge-detect history=0.
- V = min(32, 1<<mmenable). Source i maps to vector i & (V-1). Multiple sources may collapse onto one vector; any of them sets it.
- Mask register: loaded from cfg_interrupt_msi_data on mask_update. Takes effect for arbitration the following cycle.
- Pending set: edge mode sets bit on irq[i] & ~irq_d[i]; level mode sets on irq[i]. Pending is set regardless of msi_enable or mask.
- Eligible = pending & ~mask & valid_vec(V). No issue while msi_enable=0; pending is retained.
- Arbitration: round-robin, searching upward from rr pointer with wrap. After any issue, rr = issued vector + 1 (mod 32).
- FSM states:
  - IDLE: if msi_enable && eligible!=0 -> ISSUE, capturing the vector.
  - ISSUE: cfg_interrupt_msi_int = 1<<vec for exactly one cycle -> WAIT; timer cleared.
  - WAIT: sent -> clear pending[vec], stat_sent++ -> IDLE. fail, or timer reaching WAIT_TIMEOUT-1 -> stat_fail++, pending kept -> BACKOFF.
  - BACKOFF: count RETRY_DELAY cycles -> IDLE.
- Sent and fail asserted in the same cycle: treat as fail.
- Sent/fail outside WAIT: ignored, no counter change.
- Clear and set of the same pending bit in the same cycle: set wins, and the vector is re-issued later.
- msi_enable deasserting during ISSUE/WAIT: the handshake completes normally. mmenable/mask changes mid-flight do not abort.
- Minimum IDLE->IDLE issue period is 3 cycles (ISSUE, WAIT with sent in first WAIT cycle, IDLE).
- pending_status is registered: pending & valid_vec. data_enable pulses 1 cycle after any change of that value.
- Counters saturate at all-ones.

Decomposition:
- Shared package pcie_irq_pkg: FSM state encoding (IDLE, ISSUE, WAIT, BACKOFF), MSI_VEC_MAX=32, and the vector-mask function valid_vec(mmenable).
- One sub-module, rr_arb_32: combinational round-robin priority encoder (request, pointer -> grant index, grant valid). Reusable by a future MSI-X variant.

Test Plan:
- Reset mid-WAIT (rst_n low 1 cycle during WAIT of vec 3) -> int=0, pending_status=0, busy=0 on the next clk edge; no spurious pulse after release.
- enable=1, mmenable=5, irq[2] and irq[7] rise in the same cycle, sent returned 1 cycle after each int -> int=0x4 then 0x80, with the second pulse exactly 3 cycles after the first; stat_sent=2.
- mmenable=1 (V=2), irq[5] rises -> vector 1 issued (int=0x2).
- Mask=0x1 loaded, irq[0] rises -> pending_status=0x1 with no int. Mask=0 loaded -> int=0x1 within 2 cycles.
- fail on first attempt of vec 4, RETRY_DELAY=16 -> second int=0x10 no earlier than 16 cycles after fail; stat_fail=1.
- No response, WAIT_TIMEOUT=1024 -> stat_fail increments at cycle 1024 of WAIT, then retry after back-off. Sent and fail together -> counted as fail. irq[9] re-rising in the same cycle as its sent -> issued again.

Source files
------------

// File: rtl/pcie_irq_pkg.sv
// Shared definitions for the MSI interrupt arbiter.
//   msi_state_e    : arbiter FSM encoding (IDLE, ISSUE, WAIT, BACKOFF)
//   MSI_VEC_MAX    : architectural maximum number of MSI vectors
//   valid_vec()    : mask of vectors the host has enabled, from mmenable
//   vec_idx_mask() : V-1, used to fold a source index onto a vector index
package pcie_irq_pkg;

  localparam int MSI_VEC_MAX = 32;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_WAIT    = 2'd2,
    ST_BACKOFF = 2'd3
  } msi_state_e;

  // V = min(32, 1 << mmenable); one bit per usable vector.
  function automatic logic [31:0] valid_vec(input logic [2:0] mmenable);
    logic [31:0] m;
    case (mmenable)
      3'd0:    m = 32'h0000_0001;
      3'd1:    m = 32'h0000_0003;
      3'd2:    m = 32'h0000_000F;
      3'd3:    m = 32'h0000_00FF;
      3'd4:    m = 32'h0000_FFFF;
      default: m = 32'hFFFF_FFFF;
    endcase
    return m;
  endfunction

  // V - 1 as a 5-bit index mask.
  function automatic logic [4:0] vec_idx_mask(input logic [2:0] mmenable);
    logic [4:0] m;
    case (mmenable)
      3'd0:    m = 5'd0;
      3'd1:    m = 5'd1;
      3'd2:    m = 5'd3;
      3'd3:    m = 5'd7;
      3'd4:    m = 5'd15;
      default: m = 5'd31;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/pcie_msi_irq_arb_if.sv
// cfg_interrupt_msi_* bundle between the arbiter and the PCIe hard block.
//   master : arbiter side (drives int/select/pending_status)
//   slave  : hard-block side (drives enable/mmenable/mask/sent/fail)
//
// Handshake: a request is a one-cycle one-hot pulse on cfg_interrupt_msi_int.
// The hard block answers later with a one-cycle pulse on sent (delivered) or
// fail (not delivered). Only one request is outstanding at a time; responses
// that arrive while no request is outstanding are ignored. sent and fail in
// the same cycle count as fail.
interface pcie_msi_irq_arb_if;
  logic        cfg_interrupt_msi_enable;
  logic [2:0]  cfg_interrupt_msi_mmenable;
  logic        cfg_interrupt_msi_mask_update;
  logic [31:0] cfg_interrupt_msi_data;
  logic [3:0]  cfg_interrupt_msi_select;
  logic [31:0] cfg_interrupt_msi_int;
  logic        cfg_interrupt_msi_sent;
  logic        cfg_interrupt_msi_fail;
  logic [31:0] cfg_interrupt_msi_pending_status;
  logic        cfg_interrupt_msi_pending_status_data_enable;

  modport master (
    input  cfg_interrupt_msi_enable, cfg_interrupt_msi_mmenable,
           cfg_interrupt_msi_mask_update, cfg_interrupt_msi_data,
           cfg_interrupt_msi_sent, cfg_interrupt_msi_fail,
    output cfg_interrupt_msi_select, cfg_interrupt_msi_int,
           cfg_interrupt_msi_pending_status,
           cfg_interrupt_msi_pending_status_data_enable
  );

  modport slave (
    output cfg_interrupt_msi_enable, cfg_interrupt_msi_mmenable,
           cfg_interrupt_msi_mask_update, cfg_interrupt_msi_data,
           cfg_interrupt_msi_sent, cfg_interrupt_msi_fail,
    input  cfg_interrupt_msi_select, cfg_interrupt_msi_int,
           cfg_interrupt_msi_pending_status,
           cfg_interrupt_msi_pending_status_data_enable
  );
endinterface

// File: rtl/rr_arb_32.sv
// Combinational 32-way round-robin priority encoder.
//   req       : request vector
//   ptr       : highest-priority index; search runs upward from it with wrap
//   gnt_idx   : granted index (0 when nothing requested)
//   gnt_valid : at least one request present
module rr_arb_32 (
  input  logic [31:0] req,
  input  logic [4:0]  ptr,
  output logic [4:0]  gnt_idx,
  output logic        gnt_valid
);

  // Scan from the farthest offset down to offset 0 so the nearest request
  // to ptr is the last one written and therefore wins.
  always_comb begin
    gnt_idx   = '0;
    gnt_valid = 1'b0;
    for (int k = 31; k >= 0; k--) begin
      if (req[ptr + 5'(k)]) begin
        gnt_idx   = ptr + 5'(k);
        gnt_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pcie_msi_irq_arb.sv
// Multi-source MSI request arbiter in front of the PCIe cfg_interrupt_msi port.
// Sources set pending bits (folded onto the enabled vector range); eligible
// vectors (pending, unmasked, enabled) are issued one at a time round-robin,
// with timeout, back-off and retry on fail.
//   clk, rst_n      : clock, async active-low reset
//   irq             : interrupt sources (edge or level, IRQ_EDGE)
//   msi             : cfg_interrupt_msi_* bundle (master side)
//   stat_sent_count : saturating count of delivered requests
//   stat_fail_count : saturating count of failed/timed-out requests
//   busy            : FSM not idle
//   dbg_state       : current FSM state
module pcie_msi_irq_arb
  import pcie_irq_pkg::*;
#(
  parameter int IRQ_COUNT    = 32,
  parameter int IRQ_EDGE     = 1,
  parameter int RETRY_DELAY  = 16,
  parameter int WAIT_TIMEOUT = 1024,
  parameter int STAT_WIDTH   = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [IRQ_COUNT-1:0]  irq,
  pcie_msi_irq_arb_if.master    msi,
  output logic [STAT_WIDTH-1:0] stat_sent_count,
  output logic [STAT_WIDTH-1:0] stat_fail_count,
  output logic                  busy,
  output msi_state_e            dbg_state
);

  localparam int TIMER_MAX = (WAIT_TIMEOUT > RETRY_DELAY) ? WAIT_TIMEOUT : RETRY_DELAY;
  localparam int TW        = $clog2(TIMER_MAX + 1);

  msi_state_e            state_q, state_d;
  logic [IRQ_COUNT-1:0]  irq_hist_q, irq_hist_d;
  logic [31:0]           pending_q, pending_d;
  logic [31:0]           mask_q, mask_d;
  logic [4:0]            rr_q, rr_d;
  logic [4:0]            vec_q, vec_d;
  logic [TW-1:0]         timer_q, timer_d;
  logic [31:0]           int_q, int_d;
  logic [31:0]           ps_q, ps_d;
  logic                  ps_de_q, ps_de_d;
  logic [STAT_WIDTH-1:0] sent_cnt_q, sent_cnt_d;
  logic [STAT_WIDTH-1:0] fail_cnt_q, fail_cnt_d;

  logic [IRQ_COUNT-1:0]  src_set;
  logic [31:0]           set_vec;
  logic [31:0]           clr_vec;
  logic [31:0]           eligible;
  logic [31:0]           vv;
  logic [4:0]            idx_mask;
  logic [4:0]            gnt_idx;
  logic                  gnt_valid;
  logic                  sent_inc;
  logic                  fail_inc;

  assign vv       = valid_vec(msi.cfg_interrupt_msi_mmenable);
  assign idx_mask = vec_idx_mask(msi.cfg_interrupt_msi_mmenable);

  // Source events folded onto vectors; several sources may share a vector.
  always_comb begin
    irq_hist_d = irq;
    src_set    = (IRQ_EDGE != 0) ? (irq & ~irq_hist_q) : irq;
    set_vec    = '0;
    for (int i = 0; i < IRQ_COUNT; i++) begin
      if (src_set[i]) set_vec[5'(i) & idx_mask] = 1'b1;
    end
  end

  // The registered mask is used, so a mask update arbitrates next cycle.
  assign eligible = pending_q & ~mask_q & vv;

  rr_arb_32 u_rr (
    .req       (eligible),
    .ptr       (rr_q),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid)
  );

  // FSM next state and handshake decisions.
  always_comb begin
    state_d  = state_q;
    vec_d    = vec_q;
    rr_d     = rr_q;
    timer_d  = timer_q;
    clr_vec  = '0;
    sent_inc = 1'b0;
    fail_inc = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (msi.cfg_interrupt_msi_enable && gnt_valid) begin
          state_d = ST_ISSUE;
          vec_d   = gnt_idx;
          rr_d    = gnt_idx + 5'd1;
        end
      end
      ST_ISSUE: begin
        state_d = ST_WAIT;
        timer_d = '0;
      end
      ST_WAIT: begin
        // fail takes precedence when both arrive together
        if (msi.cfg_interrupt_msi_fail) begin
          fail_inc = 1'b1;
          state_d  = ST_BACKOFF;
          timer_d  = '0;
        end else if (msi.cfg_interrupt_msi_sent) begin
          clr_vec[vec_q] = 1'b1;
          sent_inc       = 1'b1;
          state_d        = ST_IDLE;
        end else if (timer_q == TW'(WAIT_TIMEOUT - 1)) begin
          fail_inc = 1'b1;
          state_d  = ST_BACKOFF;
          timer_d  = '0;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      ST_BACKOFF: begin
        if (timer_q == TW'(RETRY_DELAY - 1)) state_d = ST_IDLE;
        else                                 timer_d = timer_q + 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath next values.
  always_comb begin
    // A set in the same cycle as a clear wins, so the vector goes out again.
    pending_d  = (pending_q & ~clr_vec) | set_vec;
    mask_d     = msi.cfg_interrupt_msi_mask_update ? msi.cfg_interrupt_msi_data : mask_q;
    int_d      = (state_d == ST_ISSUE) ? (32'd1 << vec_d) : '0;
    ps_d       = pending_q & vv;
    ps_de_d    = (ps_d != ps_q);
    sent_cnt_d = (sent_inc && (sent_cnt_q != '1)) ? sent_cnt_q + 1'b1 : sent_cnt_q;
    fail_cnt_d = (fail_inc && (fail_cnt_q != '1)) ? fail_cnt_q + 1'b1 : fail_cnt_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      irq_hist_q <= '0;
      pending_q  <= '0;
      mask_q     <= '0;
      rr_q       <= '0;
      vec_q      <= '0;
      timer_q    <= '0;
      int_q      <= '0;
      ps_q       <= '0;
      ps_de_q    <= 1'b0;
      sent_cnt_q <= '0;
      fail_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      irq_hist_q <= irq_hist_d;
      pending_q  <= pending_d;
      mask_q     <= mask_d;
      rr_q       <= rr_d;
      vec_q      <= vec_d;
      timer_q    <= timer_d;
      int_q      <= int_d;
      ps_q       <= ps_d;
      ps_de_q    <= ps_de_d;
      sent_cnt_q <= sent_cnt_d;
      fail_cnt_q <= fail_cnt_d;
    end
  end

  assign msi.cfg_interrupt_msi_select                     = 4'd0;
  assign msi.cfg_interrupt_msi_int                        = int_q;
  assign msi.cfg_interrupt_msi_pending_status             = ps_q;
  assign msi.cfg_interrupt_msi_pending_status_data_enable = ps_de_q;
  assign stat_sent_count = sent_cnt_q;
  assign stat_fail_count = fail_cnt_q;
  assign busy            = (state_q != ST_IDLE);
  assign dbg_state       = state_q;

endmodule
